// File: rtl/grf_multi.sv
// grf_multi: parametrised register file with NUM_RD combinational read ports,
// two prioritised write ports (port 1 wins), optional write-to-read bypass
// and a per-register pending scoreboard with a registered popcount.
module grf_multi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     set_pend,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  // Entry 0 is held at zero forever (never written, never set pending), so a
  // read of address 0 naturally returns 0 without a separate compare.
  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic [ADDR_W:0]              cnt_q, cnt_d;

  // A write to address 0 is a no-op everywhere: storage, scoreboard, bypass.
  logic wr0_en, wr1_en, set_en;
  assign wr0_en = we0 && (waddr0 != '0);
  assign wr1_en = we1 && (waddr1 != '0);
  assign set_en = set_pend && (set_addr != '0);

  // Next-state for storage, scoreboard and pending count.
  always_comb begin
    // NOTE: every variable gets its default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    regs_d = regs_q;
    pend_d = pend_q;
    cnt_d  = '0;

    // Port 1 is applied last so it overrides port 0 on an address clash.
    if (wr0_en) regs_d[waddr0] = wdata0;
    if (wr1_en) regs_d[waddr1] = wdata1;

    // Flush dominates; otherwise a set beats a retiring write.
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wr0_en) pend_d[waddr0] = 1'b0;
      if (wr1_en) pend_d[waddr1] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
    end

    // Popcount of the post-edge scoreboard, registered alongside it.
    for (int i = 1; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage array is reset on purpose: contents must read as
      // zero straight out of reset, not as whatever powered up.
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its next-state regardless of statement order.
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // Combinational read ports with optional same-cycle forwarding.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              hit0, hit1;

    assign rd_addr = raddr[k*ADDR_W +: ADDR_W];

    // Forwarding is disabled while in reset; wrX_en already excludes addr 0.
    assign hit1 = BYP && reset_n && wr1_en && (waddr1 == rd_addr);
    assign hit0 = BYP && reset_n && wr0_en && (waddr0 == rd_addr);

    assign rdata[k*DATA_W +: DATA_W] = !reset_n ? '0     :
                                       hit1     ? wdata1 :
                                       hit0     ? wdata0 :
                                                  regs_q[rd_addr];

    // A forwarded value is already complete, so it is not reported pending.
    assign rpend[k] = reset_n && !hit0 && !hit1 && pend_q[rd_addr];
  end

endmodule

// File: tb/tb_grf_multi.sv
// Scoreboard bench for grf_multi: one instance with bypass, one without,
// sharing the same stimulus. The stimulus process derives expected outputs
// from a plain array model and queues them; a negedge monitor compares.
module tb_grf_multi;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR*AW-1:0]  raddr;
  logic              set_pend;
  logic [AW-1:0]     set_addr;
  logic              flush;

  logic [NR*DW-1:0]  rd_b, rd_n;
  logic [NR-1:0]     rp_b, rp_n;
  logic [AW:0]       cnt_b, cnt_n;

  always #5 clk = ~clk;

  grf_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rd_b), .rpend(rp_b),
    .set_pend(set_pend), .set_addr(set_addr), .flush(flush),
    .pend_cnt(cnt_b)
  );

  grf_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rd_n), .rpend(rp_n),
    .set_pend(set_pend), .set_addr(set_addr), .flush(flush),
    .pend_cnt(cnt_n)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_pend [DEPTH];

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] rd_b;
    logic [NR*DW-1:0] rd_n;
    logic [NR-1:0]    rp_b;
    logic [NR-1:0]    rp_n;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!reset_n || a == 0) return '0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return m_reg[a];
  endfunction

  function automatic logic exp_rp(input logic [AW-1:0] a, input bit byp);
    if (!reset_n || a == 0) return 1'b0;
    if (byp && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  // Apply one clock edge's worth of architectural effect to the model.
  task automatic model_edge();
    if (we0 && waddr0 != 0) m_reg[waddr0] = wdata0;
    if (we1 && waddr1 != 0) m_reg[waddr1] = wdata1;
    for (int r = 1; r < DEPTH; r++) begin
      if (flush)                                               m_pend[r] = 1'b0;
      else if (set_pend && set_addr == r)                      m_pend[r] = 1'b1;
      else if ((we0 && waddr0 == r) || (we1 && waddr1 == r))   m_pend[r] = 1'b0;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    logic [AW-1:0] a;
    e.tag = tag;
    for (int k = 0; k < NR; k++) begin
      a = raddr[k*AW +: AW];
      e.rd_b[k*DW +: DW] = exp_rd(a, 1'b1);
      e.rd_n[k*DW +: DW] = exp_rd(a, 1'b0);
      e.rp_b[k] = exp_rp(a, 1'b1);
      e.rp_n[k] = exp_rp(a, 1'b0);
    end
    e.cnt = (AW+1)'(m_count());
    sb.push_back(e);
  endtask

  // One cycle: inputs already driven (just after a posedge).
  task automatic step(input string tag);
    if (!reset_n) model_clear();
    push_exp(tag);
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    set_pend = 1'b0; set_addr = '0; flush = 1'b0;
    raddr = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  function automatic logic [AW-1:0] pick_raddr();
    case ($urandom_range(0, 3))
      0:       return waddr0;
      1:       return waddr1;
      default: return pick_addr();
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".rdata_byp"}, 64'(rd_b),  64'(e.rd_b));
        check({e.tag, ".rdata_nob"}, 64'(rd_n),  64'(e.rd_n));
        check({e.tag, ".rpend_byp"}, 64'(rp_b),  64'(e.rp_b));
        check({e.tag, ".rpend_nob"}, 64'(rp_n),  64'(e.rp_n));
        check({e.tag, ".cnt_byp"},   64'(cnt_b), 64'(e.cnt));
        check({e.tag, ".cnt_nob"},   64'(cnt_n), 64'(e.cnt));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    idle();
    model_clear();
    @(posedge clk);
    #1;

    // Held in reset: writes ignored, no forwarding.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA_0005; rd(5, 0);
    step("rst_hold");
    step("rst_hold2");

    // Populate, mark pending, then reset asynchronously mid-cycle.
    reset_n = 1'b1;
    idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h5555_0005; rd(5, 6);
    step("wr_r5");
    idle(); set_pend = 1'b1; set_addr = 5'd5;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h6666_0006; rd(5, 6);
    step("pend_r5");
    idle(); rd(5, 6);
    step("rd_r5_r6");
    idle(); reset_n = 1'b0; we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; rd(5, 6);
    step("rst_async");
    reset_n = 1'b1;
    idle(); rd(5, 6);
    step("post_rst");

    // Bypass vs. stored path.
    idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF; rd(3, 0);
    step("byp_wr3");
    idle(); rd(3, 3);
    step("rd3");

    // Write conflict: port 1 wins.
    idle(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; rd(7, 7);
    step("conflict7");
    idle(); rd(7, 0);
    step("rd7");

    // Register 0 is immune to writes and pending marks.
    idle(); we0 = 1'b1; waddr0 = '0; wdata0 = 32'hFFFF_FFFF;
    we1 = 1'b1; waddr1 = '0; wdata1 = 32'hFFFF_FFFF;
    set_pend = 1'b1; set_addr = '0; rd(0, 0);
    step("r0_write");
    idle(); rd(0, 0);
    step("r0_read");

    // Scoreboard: set, set-beats-clear, clear by port 1.
    idle(); set_pend = 1'b1; set_addr = 5'd9; rd(9, 0);
    step("set9");
    idle(); rd(9, 0);
    step("pend9");
    idle(); set_pend = 1'b1; set_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99; rd(9, 9);
    step("set_wr9");
    idle(); rd(9, 0);
    step("still9");
    idle(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h999; rd(9, 0);
    step("clr9");
    idle(); rd(9, 0);
    step("clr9_after");

    // Flush wipes pending, ignores the concurrent set, keeps data.
    for (int r = 1; r <= 3; r++) begin
      idle(); set_pend = 1'b1; set_addr = AW'(r); rd(AW'(r), 0);
      step("set_r123");
    end
    idle(); rd(1, 2);
    step("pend3");
    idle(); flush = 1'b1; set_pend = 1'b1; set_addr = 5'd4; rd(4, 3);
    step("flush");
    idle(); rd(4, 3);
    step("post_flush");

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      we0      = $urandom_range(0, 1) == 1;
      waddr0   = pick_addr();
      wdata0   = $urandom;
      we1      = $urandom_range(0, 2) == 0;
      waddr1   = $urandom_range(0, 3) == 0 ? waddr0 : pick_addr();
      wdata1   = $urandom;
      set_pend = $urandom_range(0, 4) < 2;
      set_addr = $urandom_range(0, 2) == 0 ? waddr0 : pick_addr();
      flush    = $urandom_range(0, 29) == 0;
      rd(pick_raddr(), pick_raddr());
      step("rand");
    end

    reset_n = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grf_multi.md
# grf_multi

Parametrised general-purpose register file, successor to the single-write, two-read GRF. Provides NUM_RD combinational read ports and two prioritised write ports. Optional write-to-read bypass removes the need for a negedge write. A per-register pending scoreboard lets the pipeline's hazard unit see which registers have an in-flight producer. Sits in the ID stage; write ports are fed from WB (port 0) and a second retiring unit (port 1, e.g. mult/div).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W, register 0 hardwired to zero
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- rpend  out  NUM_RD  pending bit of the register addressed by each read port
- set_pend  in  1  mark set_addr as having an in-flight producer
- set_addr  in  ADDR_W  destination register being issued
- flush  in  1  clear all pending bits (pipeline flush); data untouched
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: registers 1..2**ADDR_W-1, each DATA_W bits; register 0 is not stored and always reads 0, never pending.
- Write: on posedge, if weX and waddrX != 0, reg[waddrX] <= wdataX. Both ports same nonzero address: port 1 data wins; port 0 write dropped.
- Read (combinational), per port k with address a:
  - a == 0 -> 0.
  - BYPASS=1: we1 && waddr1==a -> wdata1; else we0 && waddr0==a -> wdata0; else reg[a].
  - BYPASS=0: reg[a].
- Scoreboard, pend[1..], updated on posedge in this precedence:
  - flush=1 -> all pend <= 0; set_pend ignored that cycle.
  - else for each address r: set_pend && set_addr==r && r!=0 -> pend[r] <= 1 (set beats clear).
  - else weX && waddrX==r -> pend[r] <= 0 (either write port retires the producer).
  - else hold.
- rpend[k] = pend[raddr_k], with BYPASS=1 forced to 0 when a write to that address is in the same cycle (value already forwarded). raddr_k == 0 -> 0.
- pend_cnt: registered popcount of pend, updated in the same edge as pend (reflects post-edge state; range 0..2**ADDR_W-1).

## Timing
- Reset (reset_n low, asynchronous): all registers 0, all pend 0, pend_cnt 0 immediately, without waiting for clk. While reset_n is low: rdata all 0, rpend all 0, writes/sets ignored, bypass disabled. First write accepted on the first posedge with reset_n high.
- Write latency: stored value visible at the registered path in the cycle after the edge. With BYPASS=1, the value is visible in the same cycle as we (0 cycle); with BYPASS=0, it is visible 1 cycle later.
- Scoreboard latency: set_pend at edge N -> rpend high from after edge N; write at edge M clears it after edge M (same-cycle rpend already 0 when BYPASS=1).
- Read ports are purely combinational from raddr/we/waddr/wdata/state; no read enable, no read latency.
- No stall or back-pressure; every input is sampled every edge.

## Test plan
- Reset: drive writes, then pull reset_n low mid-cycle (no clk edge) -> rdata, rpend, pend_cnt read 0 immediately; after release, reading r5 returns 0.
- Basic/bypass: BYPASS=1, we0=1 waddr0=3 wdata0=0xDEADBEEF, raddr port0=3 same cycle -> rdata0=0xDEADBEEF before the edge; BYPASS=0 -> old value 0 until after the edge.
- Write conflict: we0=we1=1, both address 7, wdata0=0x11, wdata1=0x22 -> after the edge reg7 reads 0x22; with bypass, the same-cycle read is also 0x22.
- Register 0: write 0xFFFFFFFF to address 0 on both ports, set_pend on address 0 -> reads 0, rpend 0, pend_cnt unchanged.
- Scoreboard: set_pend on r9 -> rpend=1, pend_cnt=1. Then, in the same cycle, set_pend on r9 plus we0 to r9 -> still pending. Next cycle we1 to r9 -> pend cleared, pend_cnt=0.
- Flush: set pending on r1, r2, r3 (pend_cnt=3), then flush=1 with set_pend on r4 -> pend_cnt=0, r4 not pending; register data unchanged.
